// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: entry layout,
// saturating-counter step function and the allocation counter value.
package bp_pkg;

    localparam int BP_ENTRIES = 16;
    localparam int BP_ADDR_W  = 32;
    localparam int BP_CTR_W   = 2;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_ADDR_W - BP_IDX_W - 2;

    // Widest counter the step function handles; callers truncate to their width.
    localparam int CTR_MAX_W  = 8;

    // Counter value given to a freshly allocated entry: MSB set, rest clear.
    localparam logic [BP_CTR_W-1:0] CTR_WEAK_TAKEN = BP_CTR_W'(1) << (BP_CTR_W - 1);

    typedef struct packed {
        logic                 valid;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_CTR_W-1:0]  ctr;
    } bte_t;

    // Saturating step of a w-bit counter held in the low bits of ctr:
    // up on taken (stick at 2^w-1), down on not-taken (stick at 0).
    function automatic logic [CTR_MAX_W-1:0] ctr_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   w
    );
        logic [CTR_MAX_W-1:0] max_v;
        max_v = (CTR_MAX_W'(1) << w) - CTR_MAX_W'(1);
        if (taken)
            ctr_next = (ctr >= max_v) ? ctr : ctr + CTR_MAX_W'(1);
        else
            ctr_next = (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one entry's CTR_W-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    // Widen into the shared step function, then narrow back to this width.
    always_comb begin
        ctr_o = CTR_W'(ctr_next(CTR_MAX_W'(ctr_i), taken_i, CTR_W));
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer. Fetch reads the flop array
// combinationally; execute writes at most one entry per cycle; flush_all
// drops every valid bit. Lookups never see same-cycle updates.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush_all
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    entry_t           entry_q [ENTRIES];
    entry_t           entry_d [ENTRIES];
    logic [CTR_W-1:0] ctr_nxt [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    entry_t           f_ent;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Byte offset of the update PC carries no information for the BTB.
    logic unused_upd_lsb;
    assign unused_upd_lsb = ^upd_pc[1:0];

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Per-entry counter step, all computed in parallel; the update mux picks one.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .ctr_i   (entry_q[g].ctr),
            .taken_i (upd_taken),
            .ctr_o   (ctr_nxt[g])
        );
    end

    // Zero-latency lookup from the registered array (pre-update contents).
    always_comb begin
        f_ent        = entry_q[f_idx];
        pred_hit     = f_ent.valid && (f_ent.tag == f_tag);
        pred_taken   = pred_hit && f_ent.ctr[CTR_W-1];
        pred_next_pc = pred_taken ? f_ent.target : fetch_pc + ADDR_W'(4);
    end

    assign u_hit = entry_q[u_idx].valid && (entry_q[u_idx].tag == u_tag);

    // Next array state: flush beats update; only the indexed entry moves.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++)
            entry_d[i] = entry_q[i];
        if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++)
                entry_d[i].valid = 1'b0;
        end else if (upd_valid) begin
            if (u_hit) begin
                entry_d[u_idx].ctr = ctr_nxt[u_idx];
                if (upd_taken)
                    entry_d[u_idx].target = upd_target;
            end else if (upd_taken) begin
                // Taken miss claims the slot, evicting whatever alias lived there.
                entry_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: CTR_WEAK};
            end
        end
    end

    // Entry array flops; async reset clears every field.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++)
                entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (default parameters).
module tb_branch_target_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid, upd_taken, flush_all;
    logic [31:0] upd_pc, upd_target;

    always #5 CLK = ~CLK;

    branch_target_predictor dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .fetch_pc     (fetch_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush_all    (flush_all)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] nxt;
    } exp_t;

    typedef struct {
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic        eh;
        logic        et;
        logic [31:0] en;
    } step_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the BTB contents.
    logic        m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [1:0]  m_ctr [16];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic [3:0]  ix;
        logic [25:0] tg;
        ix = upd_pc[5:2];
        tg = upd_pc[31:6];
        if (flush_all) begin
            for (int i = 0; i < 16; i++) m_v[i] = 0;
        end else if (upd_valid) begin
            if (m_v[ix] && m_tag[ix] == tg) begin
                if (upd_taken) begin
                    if (m_ctr[ix] != 2'd3) m_ctr[ix] = m_ctr[ix] + 2'd1;
                    m_tgt[ix] = upd_target;
                end else if (m_ctr[ix] != 2'd0) begin
                    m_ctr[ix] = m_ctr[ix] - 2'd1;
                end
            end else if (upd_taken) begin
                m_v[ix] = 1; m_tag[ix] = tg; m_tgt[ix] = upd_target; m_ctr[ix] = 2'd2;
            end
        end
    endtask

    function automatic exp_t model_pred(input logic [31:0] pc);
        exp_t e;
        logic [3:0] ix;
        ix      = pc[5:2];
        e.hit   = m_v[ix] && (m_tag[ix] == pc[31:6]);
        e.taken = e.hit && m_ctr[ix][1];
        e.nxt   = e.taken ? m_tgt[ix] : pc + 32'd4;
        return e;
    endfunction

    // Advance one clock (model follows), then drop one-shot inputs.
    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        upd_valid = 0;
        flush_all = 0;
    endtask

    task automatic drive(input step_t s);
        fetch_pc   = s.fpc;
        upd_valid  = s.uv;
        upd_pc     = s.upc;
        upd_taken  = s.ut;
        upd_target = s.utgt;
        flush_all  = s.fl;
        exp_q.push_back('{hit: s.eh, taken: s.et, nxt: s.en});
    endtask

    task automatic test_reset();
        exp_t e;
        nRST = 0; upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0; flush_all = 0;
        model_reset();
        fetch_pc = 32'h100;
        exp_q.push_back('{hit: 0, taken: 0, nxt: 32'h104});
        #3;
        e = exp_q.pop_front(); n_checks++;
        if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
            n_errors++;
            $display("FAIL reset_0x100: got %b/%b/%h want %b/%b/%h", pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
        end
        fetch_pc = 32'hFFFF_FFFC;
        exp_q.push_back('{hit: 0, taken: 0, nxt: 32'h0});
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
            n_errors++;
            $display("FAIL reset_wrap: got %b/%b/%h want %b/%b/%h", pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
        end
        @(negedge CLK); nRST = 1;
        @(posedge CLK); #1;
        fetch_pc = 32'h100;
        exp_q.push_back('{hit: 0, taken: 0, nxt: 32'h104});
        @(negedge CLK);
        e = exp_q.pop_front(); n_checks++;
        if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
            n_errors++;
            $display("FAIL post_reset: got %b/%b/%h want %b/%b/%h", pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
        end
        tick();
    endtask

    // Table-driven scenario: each step's expectation is the lookup seen
    // before that step's edge.
    task automatic run_table(input string nm, input step_t t[$]);
        exp_t e;
        foreach (t[k]) begin
            drive(t[k]);
            @(negedge CLK);
            e = exp_q.pop_front(); n_checks++;
            if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
                n_errors++;
                $display("FAIL %s[%0d]: got %b/%b/%h want %b/%b/%h", nm, k, pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
            end
            tick();
        end
    endtask

    task automatic test_alloc();
        step_t t[$];
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 32'h104});
        t.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200});
        t.push_back('{32'h104, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h108});
        run_table("alloc", t);
    endtask

    task automatic test_counter();
        step_t t[$];
        t.push_back('{32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 32'h200}); // ctr 2
        t.push_back('{32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h104}); // ctr 1
        t.push_back('{32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h104}); // ctr 0
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h104}); // ctr 0 (floor)
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h104}); // ctr 1
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200}); // ctr 2
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200}); // ctr 3
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200}); // ctr 3
        t.push_back('{32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 32'h200}); // ctr 3 (ceiling)
        t.push_back('{32'h100, 1, 32'h100, 1, 32'h220, 0, 1, 1, 32'h200}); // ctr 2
        t.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h220}); // ctr 3, new target
        run_table("counter", t);
    endtask

    task automatic test_alias();
        step_t t[$];
        t.push_back('{32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 0, 32'h144});
        t.push_back('{32'h100, 1, 32'h180, 0, 32'h0,   0, 0, 0, 32'h104});
        t.push_back('{32'h140, 1, 32'h140, 0, 32'h0,   0, 1, 1, 32'h300});
        t.push_back('{32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h144});
        t.push_back('{32'h180, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h184});
        run_table("alias", t);
    endtask

    task automatic test_same_cycle();
        step_t t[$];
        t.push_back('{32'h104, 1, 32'h104, 1, 32'h400, 0, 0, 0, 32'h108});
        t.push_back('{32'h104, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h400});
        run_table("same_cycle", t);
    endtask

    task automatic test_flush();
        step_t t[$];
        exp_t  e;
        t.push_back('{32'h100, 1, 32'h108, 1, 32'h500, 0, 0, 0, 32'h104});
        t.push_back('{32'h100, 1, 32'h10C, 1, 32'h600, 0, 0, 0, 32'h104});
        t.push_back('{32'h10C, 1, 32'h100, 1, 32'h210, 0, 1, 1, 32'h600});
        t.push_back('{32'h100, 1, 32'h108, 1, 32'h700, 1, 1, 1, 32'h210});
        t.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h104});
        t.push_back('{32'h104, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h108});
        t.push_back('{32'h108, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h10C});
        t.push_back('{32'h10C, 1, 32'h100, 1, 32'h250, 0, 0, 0, 32'h110});
        t.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h250});
        run_table("flush", t);
        // Asynchronous reset mid-cycle with an update pending across the edge.
        fetch_pc = 32'h100; upd_valid = 1; upd_pc = 32'h104; upd_taken = 1; upd_target = 32'h999;
        #2; nRST = 0;
        model_reset();
        exp_q.push_back('{hit: 0, taken: 0, nxt: 32'h104});
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
            n_errors++;
            $display("FAIL async_reset: got %b/%b/%h want %b/%b/%h", pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
        end
        @(posedge CLK); #1;
        upd_valid = 0;
        @(negedge CLK); nRST = 1;
        fetch_pc = 32'h104;
        exp_q.push_back('{hit: 0, taken: 0, nxt: 32'h108});
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
            n_errors++;
            $display("FAIL reset_drops_update: got %b/%b/%h want %b/%b/%h", pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 200; k++) begin
            fetch_pc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            upd_pc     = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_target = 32'($urandom) & 32'hFFFF_FFFC;
            flush_all  = ($urandom_range(0, 29) == 0);
            exp_q.push_back(model_pred(fetch_pc));
            @(negedge CLK);
            e = exp_q.pop_front(); n_checks++;
            if ({pred_hit, pred_taken, pred_next_pc} !== {e.hit, e.taken, e.nxt}) begin
                n_errors++;
                $display("FAIL b2b[%0d] pc=%h: got %b/%b/%h want %b/%b/%h", k, fetch_pc, pred_hit, pred_taken, pred_next_pc, e.hit, e.taken, e.nxt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
